// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: 2-bit direction counter encoding
// and the saturating counter update rule.
package btb_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            default: nxt = taken ? CTR_ST  : CTR_WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_sat_counter2.sv
// Combinational next-state for one 2-bit saturating direction counter.
module btb_sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_next
);

    assign o_ctr_next = sat_ctr_next(i_ctr, i_taken);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with 2-bit direction counters.
// One-cycle registered lookup; training from execute runs on a separate port.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_lookup_en,
    input  logic [PC_WIDTH-1:0] i_lookup_pc,
    output logic                o_pred_valid,
    output logic                o_hit,
    output logic                o_predict_taken,
    output logic [PC_WIDTH-1:0] o_pred_target,
    input  logic                i_upd_en,
    input  logic [PC_WIDTH-1:0] i_upd_pc,
    input  logic                i_upd_taken,
    input  logic [PC_WIDTH-1:0] i_upd_target
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = PC_WIDTH - INDEX_BITS - 2;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_taken;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    logic [1:0]            w_ctr_next;
    logic                  w_unused_pc_bits;

    // Instruction PCs are word aligned; the low two bits carry no information.
    assign w_unused_pc_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign w_lk_idx   = i_lookup_pc[INDEX_BITS+1:2];
    assign w_lk_tag   = i_lookup_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

    assign w_upd_idx = i_upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag = i_upd_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    btb_sat_counter2 u_sat_counter (
        .i_ctr      (r_ctr[w_upd_idx]),
        .i_taken    (i_upd_taken),
        .o_ctr_next (w_ctr_next)
    );

    // Lookup response; reads the table before this edge's update (read-old).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pred_valid    <= 1'b0;
            o_hit           <= 1'b0;
            o_predict_taken <= 1'b0;
            o_pred_target   <= '0;
        end else if (i_lookup_en) begin
            o_pred_valid    <= 1'b1;
            o_hit           <= w_lk_hit;
            o_predict_taken <= w_lk_taken;
            o_pred_target   <= w_lk_taken ? r_target[w_lk_idx]
                                          : i_lookup_pc + PC_WIDTH'(4);
        end else begin
            o_pred_valid    <= 1'b0;
        end
    end

    // Table training; a flush in the same cycle drops the update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_SNT;
            end
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_upd_en) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_next;
                if (i_upd_taken) begin
                    r_target[w_upd_idx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= i_upd_target;
                r_ctr[w_upd_idx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: driver pushes expected lookup responses
// from a behavioural table model, a monitor pops and compares registered outputs.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        hit;
    logic        predict_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    branch_target_buffer #(
        .PC_WIDTH   (32),
        .INDEX_BITS (6)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_lookup_en     (lookup_en),
        .i_lookup_pc     (lookup_pc),
        .o_pred_valid    (pred_valid),
        .o_hit           (hit),
        .o_predict_taken (predict_taken),
        .o_pred_target   (pred_target),
        .i_upd_en        (upd_en),
        .i_upd_pc        (upd_pc),
        .i_upd_taken     (upd_taken),
        .i_upd_target    (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_resp;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference table: 64 entries indexed by word address modulo 64, tag = pc / 256.
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    logic [31:0] m_target [64];
    int          m_ctr    [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear(input bit full);
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            if (full) begin
                m_tag[i]    = 0;
                m_target[i] = 32'h0;
                m_ctr[i]    = 0;
            end
        end
    endtask

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t        e;
        int          idx;
        int unsigned tag;
        idx      = int'((pc >> 2) % 64);
        tag      = pc >> 8;
        e.hit    = m_valid[idx] && (m_tag[idx] == tag);
        e.taken  = e.hit && (m_ctr[idx] >= 2);
        e.target = e.taken ? m_target[idx] : pc + 32'd4;
        return e;
    endfunction

    task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int          idx;
        int unsigned tag;
        idx = int'((pc >> 2) % 64);
        tag = pc >> 8;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (taken) begin
                m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (taken) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = tag;
            m_target[idx] = tgt;
            m_ctr[idx]    = 2;
        end
    endtask

    task automatic cycle(input bit le, input logic [31:0] lpc,
                         input bit ue, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utg, input bit fl);
        @(negedge clk);
        lookup_en  = le;
        lookup_pc  = lpc;
        upd_en     = ue;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        flush      = fl;
        if (le) exp_q.push_back(model_lookup(lpc));
        if (fl) model_clear(1'b0);
        else if (ue) model_update(upc, ut, utg);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        cycle(1'b0, 32'h0, 1'b1, pc, taken, tgt, 1'b0);
    endtask

    // Monitor: one expected response per cycle in which a lookup was sampled.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (pred_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got pred_valid 1, expected 0 at %0t",
                             $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hit", {31'h0, hit}, {31'h0, e.hit});
                    check("predict_taken", {31'h0, predict_taken}, {31'h0, e.taken});
                    check("pred_target", pred_target, e.target);
                    last_resp = e;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_response: got pred_valid 0, expected 1 at %0t",
                             $time);
                end
                check("hold_hit", {31'h0, hit}, {31'h0, last_resp.hit});
                check("hold_taken", {31'h0, predict_taken}, {31'h0, last_resp.taken});
                check("hold_target", pred_target, last_resp.target);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        lookup_en  = 1'b0;
        lookup_pc  = 32'h0;
        upd_en     = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        last_resp  = '0;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        check("reset_valid", {31'h0, pred_valid}, 32'h0);
        check("reset_hit", {31'h0, hit}, 32'h0);
        check("reset_taken", {31'h0, predict_taken}, 32'h0);
        check("reset_target", pred_target, 32'h0);
        rst_n = 1'b1;

        // Cold miss, allocation, counter walk with saturation at both ends.
        look(32'h0040_0010);
        train(32'h0040_0010, 1'b1, 32'h0040_0100);
        look(32'h0040_0010);
        train(32'h0040_0010, 1'b0, 32'h0);
        train(32'h0040_0010, 1'b0, 32'h0);
        look(32'h0040_0010);
        train(32'h0040_0010, 1'b0, 32'h0);
        look(32'h0040_0010);
        for (int i = 0; i < 4; i++) begin
            train(32'h0040_0010, 1'b1, 32'h0040_0100);
            look(32'h0040_0010);
        end
        train(32'h0040_0010, 1'b0, 32'h0);
        look(32'h0040_0010);

        // Alias on the same index with a different tag.
        look(32'h0040_0110);
        train(32'h0040_0110, 1'b1, 32'h0000_0200);
        look(32'h0040_0010);
        look(32'h0040_0110);

        // Same-cycle lookup and allocation to an empty index: read-old.
        cycle(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0800, 1'b0);
        look(32'h0040_0020);

        // Flush beats a simultaneous update; the flush-cycle lookup sees old contents.
        cycle(1'b1, 32'h0040_0110, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_0900, 1'b1);
        look(32'h0040_0110);
        look(32'h0040_0030);
        look(32'h0040_0020);

        // Async reset between two lookups clears outputs without a clock edge.
        train(32'h0040_0040, 1'b1, 32'h0040_0400);
        look(32'h0040_0040);
        look(32'h0040_0040);
        @(negedge clk);
        lookup_en = 1'b1;
        lookup_pc = 32'h0040_0040;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, pred_valid}, 32'h0);
        check("async_rst_hit", {31'h0, hit}, 32'h0);
        check("async_rst_taken", {31'h0, predict_taken}, 32'h0);
        check("async_rst_target", pred_target, 32'h0);
        exp_q.delete();
        last_resp = '0;
        model_clear(1'b1);
        @(negedge clk);
        lookup_en = 1'b0;
        rst_n     = 1'b1;
        look(32'h0040_0040);

        // Randomised traffic over a small PC pool to force hits, aliases and saturation.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] lpc;
            logic [31:0] upc;
            logic [31:0] tgt;
            lpc = 32'h0040_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
                  | $urandom_range(0, 3);
            upc = 32'h0040_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
                  | $urandom_range(0, 3);
            tgt = $urandom & 32'hffff_fffc;
            cycle(($urandom_range(0, 3) != 0), lpc, ($urandom_range(0, 1) != 0), upc,
                  ($urandom_range(0, 2) != 0), tgt, ($urandom_range(0, 79) == 0));
        end

        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
